mem_stage_ctrl: RTL and testbench

- Parametrised memory-stage controller sitting between the execute/memory pipeline register and the data memory system (cache + backing memory, Rd/Wr/Stall/Done handshake).
- Latches one load/store request, holds the request strobes to the memory system until Done, captures read data, and drives the pipeline stall.
- Adds behaviour the current memory stage lacks: wait-cycle timeout, misaligned-access detection, and a sticky error report.
- Generalised in data width, address width and timeout depth.

---
 rtl/mem_stage_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: latches one load/store, holds strobes to the memory system
// until done or timeout, captures read data, and reports a sticky first-error code.
module mem_stage_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MAX_WAIT    = 63,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic              in_wr,
    input  logic              in_dump,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_createdump,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_rdata,
    output logic              pipe_stall,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CODE_MEMERR   = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d, mwr_q, mwr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              dump_q, cdump_q;
    logic              misalign, timeout;

    // mem_stall is informational only; mem_done alone ends an access
    logic unused_stall;
    assign unused_stall = mem_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            mwr_q   <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            dump_q  <= 1'b0;
            cdump_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            mwr_q   <= mwr_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
            dump_q  <= in_dump;
            cdump_q <= in_dump & ~dump_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        mwr_d      = mwr_q;
        valid_d    = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        code_d     = code_q;
        pipe_stall = 1'b0;
        misalign   = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_en) begin
                    pipe_stall = 1'b1;
                    if ((ALIGN_CHECK != 0) && in_addr[0]) begin
                        misalign = 1'b1;
                        rdata_d  = '0;
                        valid_d  = 1'b1;
                        state_d  = RESP;
                    end else begin
                        addr_d  = in_addr;
                        wdata_d = in_wdata;
                        wr_d    = in_wr;
                        cnt_d   = '0;
                        rd_d    = ~in_wr;
                        mwr_d   = in_wr;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                pipe_stall = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                // completion wins over a timeout landing on the same cycle
                if (mem_done) begin
                    rdata_d = wr_q ? '0 : mem_rdata;
                    rd_d    = 1'b0;
                    mwr_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == LAST_WAIT) begin
                    timeout = 1'b1;
                    rdata_d = '0;
                    rd_d    = 1'b0;
                    mwr_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (misalign || timeout || mem_err) begin
            err_d = 1'b1;
            if (!err_q) begin
                code_d = misalign ? CODE_MISALIGN : (timeout ? CODE_TIMEOUT : CODE_MEMERR);
            end
        end
    end

    assign mem_rd         = rd_q;
    assign mem_wr         = mwr_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_createdump = cdump_q;
    assign out_valid      = valid_q;
    assign out_rdata      = rdata_q;
    assign err            = err_q;
    assign err_code       = code_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a 16-bit instance with MAX_WAIT=8 and alignment
// checking, and a 32/24-bit instance with alignment checking disabled.
module tb_mem_stage_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // instance a: DATA_W=16, ADDR_W=16, MAX_WAIT=8, ALIGN_CHECK=1
    logic        a_en, a_wr, a_dump, a_stall, a_done, a_merr;
    logic [15:0] a_addr, a_wdata, a_rdata_in;
    logic        a_rd, a_mwr, a_cdump, a_valid, a_pstall, a_err;
    logic [15:0] a_maddr, a_mwdata, a_rdata;
    logic [1:0]  a_code;

    // instance b: DATA_W=32, ADDR_W=24, MAX_WAIT=63, ALIGN_CHECK=0
    logic        b_en, b_wr, b_dump, b_stall, b_done, b_merr;
    logic [23:0] b_addr, b_maddr;
    logic [31:0] b_wdata, b_rdata_in, b_mwdata, b_rdata;
    logic        b_rd, b_mwr, b_cdump, b_valid, b_pstall, b_err;
    logic [1:0]  b_code;

    mem_stage_ctrl #(.DATA_W(16), .ADDR_W(16), .MAX_WAIT(8), .ALIGN_CHECK(1)) dut_a (
        .clk(clk), .rst(rst), .in_en(a_en), .in_wr(a_wr), .in_dump(a_dump),
        .in_addr(a_addr), .in_wdata(a_wdata), .mem_rd(a_rd), .mem_wr(a_mwr),
        .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_createdump(a_cdump),
        .mem_stall(a_stall), .mem_done(a_done), .mem_rdata(a_rdata_in), .mem_err(a_merr),
        .out_valid(a_valid), .out_rdata(a_rdata), .pipe_stall(a_pstall),
        .err(a_err), .err_code(a_code)
    );

    mem_stage_ctrl #(.DATA_W(32), .ADDR_W(24), .MAX_WAIT(63), .ALIGN_CHECK(0)) dut_b (
        .clk(clk), .rst(rst), .in_en(b_en), .in_wr(b_wr), .in_dump(b_dump),
        .in_addr(b_addr), .in_wdata(b_wdata), .mem_rd(b_rd), .mem_wr(b_mwr),
        .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_createdump(b_cdump),
        .mem_stall(b_stall), .mem_done(b_done), .mem_rdata(b_rdata_in), .mem_err(b_merr),
        .out_valid(b_valid), .out_rdata(b_rdata), .pipe_stall(b_pstall),
        .err(b_err), .err_code(b_code)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs are then driven at +1 and outputs sampled at +2
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {a_en, a_wr, a_dump, a_stall, a_done, a_merr} = '0;
        a_addr = '0; a_wdata = '0; a_rdata_in = '0;
        {b_en, b_wr, b_dump, b_stall, b_done, b_merr} = '0;
        b_addr = '0; b_wdata = '0; b_rdata_in = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_rd", a_rd, 0);
        chk("rst_wr", a_mwr, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_pstall", a_pstall, 0);
        chk("rst_err", a_err, 0);
        chk("rst_code", a_code, 0);
        chk("rst_addr", a_maddr, 0);
        chk("rst_cdump", a_cdump, 0);

        // load hit: accept cycle 0, done cycle 1, valid cycle 2
        step();
        a_en = 1'b1; a_wr = 1'b0; a_addr = 16'h0040;
        #1 chk("ld_c0_pstall", a_pstall, 1);
        step();
        a_en = 1'b0; a_done = 1'b1; a_rdata_in = 16'hBEEF;
        #1;
        chk("ld_c1_rd", a_rd, 1);
        chk("ld_c1_wr", a_mwr, 0);
        chk("ld_c1_addr", a_maddr, 16'h0040);
        chk("ld_c1_pstall", a_pstall, 1);
        chk("ld_c1_valid", a_valid, 0);
        step();
        a_done = 1'b0; a_rdata_in = 16'h0000;
        #1;
        chk("ld_c2_valid", a_valid, 1);
        chk("ld_c2_rdata", a_rdata, 16'hBEEF);
        chk("ld_c2_rd", a_rd, 0);
        chk("ld_c2_pstall", a_pstall, 0);
        step();
        #1;
        chk("ld_c3_valid", a_valid, 0);
        chk("ld_c3_rdata_hold", a_rdata, 16'hBEEF);

        // store miss: done after 4 BUSY cycles
        a_en = 1'b1; a_wr = 1'b1; a_addr = 16'h0102; a_wdata = 16'h1234;
        step();
        a_en = 1'b0; a_wr = 1'b0; a_addr = 16'h0; a_wdata = 16'h0;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) a_done = 1'b1;
            #1;
            chk("st_wr", a_mwr, 1);
            chk("st_rd", a_rd, 0);
            chk("st_addr", a_maddr, 16'h0102);
            chk("st_wdata", a_mwdata, 16'h1234);
            chk("st_pstall", a_pstall, 1);
            step();
        end
        a_done = 1'b0;
        #1;
        chk("st_valid", a_valid, 1);
        chk("st_rdata", a_rdata, 0);
        chk("st_wr_drop", a_mwr, 0);
        step();
        #1 chk("st_valid_once", a_valid, 0);

        // done on the 8th BUSY cycle beats the timeout
        a_en = 1'b1; a_addr = 16'h0200;
        step();
        a_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) begin
                a_done = 1'b1; a_rdata_in = 16'h5A5A;
            end
            #1 chk("to8_rd", a_rd, 1);
            step();
        end
        a_done = 1'b0;
        #1;
        chk("to8_valid", a_valid, 1);
        chk("to8_rdata", a_rdata, 16'h5A5A);
        chk("to8_err", a_err, 0);
        step();

        // no done at all: timeout after 8 BUSY cycles
        a_en = 1'b1; a_addr = 16'h0204;
        step();
        a_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1 chk("to_rd", a_rd, 1);
            step();
        end
        #1;
        chk("to_rd_drop", a_rd, 0);
        chk("to_valid", a_valid, 1);
        chk("to_rdata", a_rdata, 0);
        chk("to_err", a_err, 1);
        chk("to_code", a_code, 2'b10);
        step();

        // misaligned access never reaches memory
        do_reset();
        a_en = 1'b1; a_wr = 1'b0; a_addr = 16'h0011;
        #1 chk("mis_pstall", a_pstall, 1);
        step();
        a_en = 1'b0; a_addr = 16'h0;
        #1;
        chk("mis_rd", a_rd, 0);
        chk("mis_wr", a_mwr, 0);
        chk("mis_valid", a_valid, 1);
        chk("mis_err", a_err, 1);
        chk("mis_code", a_code, 2'b01);
        a_merr = 1'b1;
        step();
        a_merr = 1'b0;
        #1;
        chk("mis_valid_once", a_valid, 0);
        chk("first_err_wins", a_code, 2'b01);

        // reset in BUSY cycle 2 abandons the access
        do_reset();
        a_en = 1'b1; a_addr = 16'h0300;
        step();
        a_en = 1'b0;
        #1 chk("rb_c1_rd", a_rd, 1);
        step();
        #1 chk("rb_c2_rd", a_rd, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rb_rd", a_rd, 0);
        chk("rb_pstall", a_pstall, 0);
        chk("rb_addr", a_maddr, 0);
        chk("rb_valid", a_valid, 0);
        a_en = 1'b1; a_addr = 16'h0042;
        step();
        a_en = 1'b0; a_done = 1'b1; a_rdata_in = 16'h7777;
        #1 chk("rb_new_rd", a_rd, 1);
        step();
        a_done = 1'b0;
        #1;
        chk("rb_new_valid", a_valid, 1);
        chk("rb_new_rdata", a_rdata, 16'h7777);
        chk("rb_new_err", a_err, 0);

        // mem_err with no prior error
        a_merr = 1'b1;
        step();
        a_merr = 1'b0;
        #1;
        chk("merr_err", a_err, 1);
        chk("merr_code", a_code, 2'b11);

        // dump: one pulse per rising edge of in_dump
        a_dump = 1'b1;
        #1 chk("dump_pre", a_cdump, 0);
        step();
        #1 chk("dump_pulse", a_cdump, 1);
        step();
        #1 chk("dump_held", a_cdump, 0);
        a_dump = 1'b0;
        step();
        #1 chk("dump_low", a_cdump, 0);

        // wide instance: odd address is a normal access with alignment check off
        b_en = 1'b1; b_wr = 1'b0; b_addr = 24'hAB0041;
        step();
        b_en = 1'b0; b_done = 1'b1; b_rdata_in = 32'hDEADBEEF;
        #1;
        chk("w_rd", b_rd, 1);
        chk("w_addr", b_maddr, 24'hAB0041);
        step();
        b_done = 1'b0;
        #1;
        chk("w_valid", b_valid, 1);
        chk("w_rdata", b_rdata, 32'hDEADBEEF);
        chk("w_err", b_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
